// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store, one read outstanding.
// Optional build macro DATA_PRIORITY_EN: on a tie the data port always wins (default is round-robin).
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);

  state_t     state_q, state_d;
  logic [2:0] lat_q, lat_d;
  logic       last_d_q, last_d_d;   // 1: data port took the most recent grant
  logic       owner_d_q, owner_d_d; // 1: outstanding read belongs to the data port

  logic issue, resp, pick_i, pick_d, win, grant, rd_grant;

  always_comb begin
    issue = (state_q == IDLE) || (lat_q == 3'd1);
    resp  = (state_q == RD_WAIT) && (lat_q == 3'd1);

`ifdef DATA_PRIORITY_EN
    pick_i = i_req && !d_req;
`else
    pick_i = i_req && (!d_req || last_d_q);
`endif
    pick_d   = d_req && !pick_i;
    win      = issue && (pick_i || pick_d);
    grant    = win && mem_ready;
    rd_grant = grant && (pick_i || !d_we);

    // Outputs are forced low while reset is held, even though they are combinational.
    mem_req   = reset && win;
    mem_we    = reset && win && pick_d && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset && win) begin
      mem_addr  = pick_d ? d_addr : i_addr;
      mem_wdata = (pick_d && d_we) ? d_wdata : 32'd0;
    end

    i_gnt    = reset && grant && pick_i;
    d_gnt    = reset && grant && pick_d;
    i_rvalid = reset && resp && !owner_d_q;
    d_rvalid = reset && resp && owner_d_q;
    i_rdata  = i_rvalid ? mem_rdata : 32'd0;
    d_rdata  = d_rvalid ? mem_rdata : 32'd0;
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    last_d_d  = last_d_q;
    owner_d_d = owner_d_q;

    if (state_q == RD_WAIT) begin
      lat_d = lat_q - 3'd1;
      if (lat_q == 3'd1) begin
        state_d = IDLE;
        lat_d   = 3'd0;
      end
    end

    // A read accepted in the response cycle reloads the counter (overlapped issue).
    if (rd_grant) begin
      state_d   = RD_WAIT;
      lat_d     = LAT_INIT;
      owner_d_d = pick_d;
    end

    if (grant) begin
      last_d_d = pick_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_q     <= 3'd0;
      last_d_q  <= 1'b1;
      owner_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      last_d_q  <= last_d_d;
      owner_d_q <= owner_d_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector table for mem_port_arbiter (MEM_LATENCY = 2), plus hand sequences for reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        rdy;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic        igt;
    logic        ivld;
    logic [31:0] irdata;
    logic        dgt;
    logic        dvld;
    logic [31:0] drdata;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t iv(logic rst, logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
                             logic [31:0] daddr, logic [31:0] dwdata, logic rdy, logic [31:0] rdata);
    return '{rst, ireq, iaddr, dreq, dwe, daddr, dwdata, rdy, rdata};
  endfunction

  function automatic out_t ov(logic igt, logic ivld, logic [31:0] irdata, logic dgt, logic dvld,
                              logic [31:0] drdata, logic mreq, logic mwe, logic [31:0] maddr,
                              logic [31:0] mwdata);
    return '{igt, ivld, irdata, dgt, dvld, drdata, mreq, mwe, maddr, mwdata};
  endfunction

  task automatic add(string name, in_t i, out_t o);
    vec_t v;
    v.name = name;
    v.in   = i;
    v.exp  = o;
    vecs.push_back(v);
  endtask

  task automatic drive(in_t v);
    reset     = v.rst;
    i_req     = v.ireq;
    i_addr    = v.iaddr;
    d_req     = v.dreq;
    d_we      = v.dwe;
    d_addr    = v.daddr;
    d_wdata   = v.dwdata;
    mem_ready = v.rdy;
    mem_rdata = v.rdata;
  endtask

  function automatic out_t sample();
    return '{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  localparam out_t ZERO = '0;

  initial begin
    drive(iv(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state and fetch-only read
    add("rst_outs",   iv(0, 1, 32'h100, 1, 0, 32'h20, 0, 1, 0), ZERO);
    add("idle",       iv(1, 0, 0, 0, 0, 0, 0, 1, 0),           ZERO);
    add("f_gnt",      iv(1, 1, 32'h100, 0, 0, 0, 0, 1, 0),      ov(1, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0));
    add("f_wait",     iv(1, 0, 0, 0, 0, 0, 0, 1, 0),            ZERO);
    add("f_rvalid",   iv(1, 0, 0, 0, 0, 0, 0, 1, 32'h2408000A), ov(0, 1, 32'h2408000A, 0, 0, 0, 0, 0, 0, 0));
    add("f_after",    iv(1, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF), ZERO);
    // Round-robin after a fresh reset: I at T, D at T+2, I at T+4
    add("rr_rst",     iv(0, 1, 32'h10, 1, 0, 32'h20, 0, 1, 0),  ZERO);
    add("rr_i0",      iv(1, 1, 32'h10, 1, 0, 32'h20, 0, 1, 0),  ov(1, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0));
    add("rr_blk0",    iv(1, 1, 32'h10, 1, 0, 32'h20, 0, 1, 0),  ZERO);
    add("rr_d1",      iv(1, 1, 32'h10, 1, 0, 32'h20, 0, 1, 32'h11111111), ov(0, 1, 32'h11111111, 1, 0, 0, 1, 0, 32'h20, 0));
    add("rr_blk1",    iv(1, 1, 32'h10, 1, 0, 32'h20, 0, 1, 0),  ZERO);
    add("rr_i2",      iv(1, 1, 32'h10, 1, 0, 32'h20, 0, 1, 32'h22222222), ov(1, 0, 0, 0, 1, 32'h22222222, 1, 0, 32'h10, 0));
    add("rr_blk2",    iv(1, 0, 0, 0, 0, 0, 0, 1, 0),            ZERO);
    add("rr_ivld",    iv(1, 0, 0, 0, 0, 0, 0, 1, 32'h33333333), ov(0, 1, 32'h33333333, 0, 0, 0, 0, 0, 0, 0));
    // Back-to-back stores, no response
    add("st0",        iv(1, 0, 0, 1, 1, 32'h200, 32'hAA, 1, 0), ov(0, 0, 0, 1, 0, 0, 1, 1, 32'h200, 32'hAA));
    add("st1",        iv(1, 0, 0, 1, 1, 32'h204, 32'hBB, 1, 0), ov(0, 0, 0, 1, 0, 0, 1, 1, 32'h204, 32'hBB));
    add("st_norsp",   iv(1, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A), ZERO);
    // Backpressure: request held stable until mem_ready
    add("bp0",        iv(1, 1, 32'h40, 0, 0, 0, 0, 0, 0),       ov(0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0));
    add("bp1",        iv(1, 1, 32'h40, 0, 0, 0, 0, 0, 0),       ov(0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0));
    add("bp2",        iv(1, 1, 32'h40, 0, 0, 0, 0, 0, 0),       ov(0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0));
    add("bp_gnt",     iv(1, 1, 32'h40, 0, 0, 0, 0, 1, 0),       ov(1, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0));
    add("bp_wait",    iv(1, 0, 0, 0, 0, 0, 0, 1, 0),            ZERO);
    add("bp_rvalid",  iv(1, 0, 0, 0, 0, 0, 0, 1, 32'h44),       ov(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0));
    // Tie under backpressure: last grant was I, so D wins and keeps winning while stalled
    add("tbp0",       iv(1, 1, 32'h30, 1, 0, 32'h80, 0, 0, 0),  ov(0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 0));
    add("tbp_gnt",    iv(1, 1, 32'h30, 1, 0, 32'h80, 0, 1, 0),  ov(0, 0, 0, 1, 0, 0, 1, 0, 32'h80, 0));
    add("tbp_wait",   iv(1, 0, 0, 0, 0, 0, 0, 1, 0),            ZERO);
    add("tbp_dvld",   iv(1, 0, 0, 0, 0, 0, 0, 1, 32'h55),       ov(0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0));

    repeat (2) @(posedge clk);

`ifndef DATA_PRIORITY_EN
    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      drive(vecs[k].in);
      #3;
      chk_out(vecs[k].name, sample(), vecs[k].exp);
    end

    // Reset mid-read: read granted at T, reset low T+1..T+3
    @(posedge clk); #1;
    drive(iv(1, 1, 32'h300, 0, 0, 32'h500, 0, 1, 32'h77));
    #3; chk("mr_gnt", {31'd0, i_gnt}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b1;
    #1; chk_out("mr_async_zero", sample(), ZERO);
    @(posedge clk); #4;
    chk_out("mr_rst_zero", sample(), ZERO);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b0;
    #3;
    chk("mr_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("mr_tie_i", {31'd0, mem_req}, 32'd1);
    chk("mr_tie_addr", mem_addr, 32'h300);
    chk("mr_no_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    #3; chk_out("mr_after0", sample(), ZERO);
    @(posedge clk); #4;
    chk_out("mr_after1", sample(), ZERO);
`else
    // Data priority: D takes every tie, fetch waits until d_req drops
    @(posedge clk); #1;
    drive(iv(0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    drive(iv(1, 1, 32'h10, 1, 0, 32'h20, 0, 1, 0));
    for (int n = 0; n < 6; n++) begin
      #3;
      chk($sformatf("dp_dgnt%0d", n), {31'd0, d_gnt}, (n % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("dp_ignt%0d", n), {31'd0, i_gnt}, 32'd0);
      @(posedge clk); #1;
    end
    d_req = 1'b0;
    #3; chk("dp_i_after", {31'd0, i_gnt}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and its data load/store port.
- Sits between the mips core and the memory model. It replaces the two separate instr/data memories with one physical port.
- Arbitrates per request and tracks a single outstanding read with a fixed-latency counter.
- Steers returned read data to the requester that issued the read.

Parameters:
- MEM_LATENCY, default 2: cycles from read acceptance to read data valid on mem_rdata. Legal range 1..7.
- ADDR_W, default 32: address width of all ports.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- i_req  input  1  instruction fetch request; held until i_gnt.
- i_addr  input  ADDR_W  fetch address.
- i_gnt  output  1  fetch request accepted this cycle.
- i_rvalid  output  1  fetch data valid this cycle.
- i_rdata  output  32  fetch data.
- d_req  input  1  data request; held until d_gnt.
- d_we  input  1  1 = store, 0 = load. Polarity is opposite to the core's data_rd_wr; the wrapper inverts it.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  32  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  load data valid this cycle.
- d_rdata  output  32  load data.
- mem_req  output  1  request to memory.
- mem_we  output  1  write strobe to memory.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  32  memory write data.
- mem_ready  input  1  memory accepts the request this cycle.
- mem_rdata  input  32  memory read data.

Behaviour:
- Reset state (reset low, asynchronous):
  - FSM = IDLE, lat_cnt = 0.
  - last_grant = DATA, so the instruction port wins the first tie.
  - All outputs 0: i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata.
- FSM states: IDLE (no read outstanding) and RD_WAIT (one read outstanding, lat_cnt counting).
- Winner selection is combinational in IDLE, and in the final RD_WAIT cycle (lat_cnt == 1):
  - Only one port requesting: that port wins.
  - Both requesting: the port opposite last_grant wins (round-robin).
- Memory request:
  - mem_req = 1 whenever a winner exists in an issuing cycle.
  - mem_addr, mem_we and mem_wdata come from the winner. mem_we = 0 and mem_wdata = 0 for an instruction winner.
- Grant:
  - winner's gnt = mem_req & mem_ready, combinational. At most one gnt per cycle.
  - last_grant updates only on a grant.
- Accepted read (instruction fetch, or data with d_we = 0) at cycle T:
  - Go to RD_WAIT with lat_cnt = MEM_LATENCY and owner register = winner.
  - lat_cnt decrements each cycle.
  - At cycle T+MEM_LATENCY (lat_cnt == 1): the owner's rvalid = 1 for exactly one cycle, and its rdata = mem_rdata (combinational pass-through).
  - The non-owner's rdata is held at 0.
- Accepted write at cycle T:
  - No response. FSM stays IDLE, so back-to-back issue is allowed next cycle.
- Response overlapping a new issue:
  - In the rvalid cycle a new request may be granted (overlapped issue).
  - If it is a read, the FSM reloads lat_cnt = MEM_LATENCY; otherwise it returns to IDLE.
- Blocking: in RD_WAIT with lat_cnt > 1, mem_req = 0 and no grants.
- mem_ready low: mem_req stays asserted with the same winner, and last_grant does not change. The losing port keeps waiting and no request is dropped.
- MEM_LATENCY == 1: the rvalid cycle is T+1, and issue is possible every cycle.
- Reset asserted mid-read: the outstanding read is discarded. No rvalid is produced after reset deasserts.
- Requester changes its request before grant: the current inputs win. No request is latched before grant.

Optional Feature:
- Macro DATA_PRIORITY_EN.
- Defined: on a tie the data port always wins, and last_grant is ignored. This minimises load/store stall at the cost of fetch starvation.
- Undefined (default): round-robin as specified above.

Test Plan:
- Fetch only, MEM_LATENCY = 2:
  - Stimulus: i_req = 1, i_addr = 0x100, mem_ready = 1 at T; mem_rdata = 0x2408000A at T+2.
  - Required: i_gnt = 1 at T; i_rvalid = 1 with i_rdata = 0x2408000A at T+2 only; d_rvalid = 0 throughout.
- Simultaneous requests after reset, round-robin build:
  - Stimulus: i_req = d_req = 1 continuously with d_we = 0.
  - Required: grants alternate I, D, I, D. I is granted at T, D at T+2, I at T+4. Each rvalid goes only to the owner.
- Back-to-back stores:
  - Stimulus: d_req = 1, d_we = 1, d_addr = 0x200 then 0x204, d_wdata = 0xAA then 0xBB.
  - Required: mem_we = 1 on two consecutive cycles with matching addr/data; d_gnt both cycles; no d_rvalid.
- Backpressure:
  - Stimulus: mem_ready = 0 for 3 cycles while i_req = 1, i_addr = 0x40.
  - Required: mem_req = 1 and mem_addr = 0x40 held stable, i_gnt = 0 for 3 cycles. Grant occurs in the first cycle mem_ready = 1.
- Reset mid-read:
  - Stimulus: read granted at T; reset low at T+1, released at T+3.
  - Required: all outputs 0 during reset; no i_rvalid/d_rvalid at or after T+2; next tie goes to I.
- DATA_PRIORITY_EN defined:
  - Stimulus: i_req = d_req = 1 for 3 consecutive reads.
  - Required: all three grants go to D; i_gnt stays 0 until d_req drops.
